// File: rtl/dmem_arbiter.sv
// Arbitrates main_mem's single data port between the core LSU (C) and the loader (L),
// and sequences the fence_i instruction-memory sync.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 14,
  parameter bit          FAIR   = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_c_req,
  input  logic              i_c_we,
  input  logic [3:0]        i_c_ben,
  input  logic [ADDR_W-1:0] i_c_addr,
  input  logic [31:0]       i_c_wdata,
  output logic              o_c_gnt,
  output logic              o_c_rvalid,
  output logic [31:0]       o_c_rdata,
  input  logic              i_l_req,
  input  logic              i_l_we,
  input  logic [3:0]        i_l_ben,
  input  logic [ADDR_W-1:0] i_l_addr,
  input  logic [31:0]       i_l_wdata,
  output logic              o_l_gnt,
  output logic              o_l_rvalid,
  output logic [31:0]       o_l_rdata,
  input  logic              i_c_fence_i,
  output logic              o_c_fence_done,
  output logic              o_dm_ren,
  output logic              o_dm_wen,
  output logic [3:0]        o_dm_ben,
  output logic [ADDR_W-1:0] o_dm_addr,
  output logic [31:0]       o_dm_wdata,
  input  logic [31:0]       i_dm_rdata,
  output logic              o_fence_i,
  input  logic              i_mem_ready
);

  typedef enum logic [1:0] {StIdle, StSync, StDrain} state_e;

  state_e      r_state, w_state_d;
  logic [1:0]  r_cnt, w_cnt_d;
  logic        r_prefer_l;
  logic        r_c_rvalid, r_l_rvalid;
  logic [31:0] r_c_rdata, r_l_rdata;
  logic        w_can_gnt, w_c_wins, w_c_gnt, w_l_gnt;

  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt;
    o_fence_i      = 1'b0;
    o_c_fence_done = 1'b0;
    w_can_gnt      = 1'b0;
    case (r_state)
      StIdle: begin
        // A pending fence blocks all grants, even while waiting for ready.
        if (i_c_fence_i) begin
          if (i_mem_ready) begin
            o_fence_i = 1'b1;
            w_cnt_d   = 2'd2;
            w_state_d = StSync;
          end
        end else begin
          w_can_gnt = i_mem_ready;
        end
      end
      StSync: begin
        // main_mem drops ready a cycle after the fence; ignore ready until the wait expires.
        if (r_cnt != 2'd0) begin
          w_cnt_d = r_cnt - 2'd1;
        end else if (i_mem_ready) begin
          o_c_fence_done = 1'b1;
          w_state_d      = StDrain;
        end
      end
      StDrain: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign w_c_wins = i_c_req & (~i_l_req | ~FAIR | ~r_prefer_l);
  assign w_c_gnt  = w_can_gnt & w_c_wins;
  assign w_l_gnt  = w_can_gnt & i_l_req & ~w_c_wins;
  assign o_c_gnt  = w_c_gnt;
  assign o_l_gnt  = w_l_gnt;

  always_comb begin
    o_dm_ren   = 1'b0;
    o_dm_wen   = 1'b0;
    o_dm_ben   = 4'd0;
    o_dm_addr  = '0;
    o_dm_wdata = 32'd0;
    if (w_c_gnt) begin
      o_dm_ren   = ~i_c_we;
      o_dm_wen   = i_c_we;
      o_dm_ben   = i_c_we ? i_c_ben : 4'd0;
      o_dm_addr  = i_c_addr;
      o_dm_wdata = i_c_wdata;
    end else if (w_l_gnt) begin
      o_dm_ren   = ~i_l_we;
      o_dm_wen   = i_l_we;
      o_dm_ben   = i_l_we ? i_l_ben : 4'd0;
      o_dm_addr  = i_l_addr;
      o_dm_wdata = i_l_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_cnt      <= 2'd0;
      r_prefer_l <= 1'b0;
      r_c_rvalid <= 1'b0;
      r_l_rvalid <= 1'b0;
      r_c_rdata  <= 32'd0;
      r_l_rdata  <= 32'd0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      if (w_c_gnt || w_l_gnt) begin
        r_prefer_l <= w_c_gnt;
      end
      r_c_rvalid <= w_c_gnt & ~i_c_we;
      r_l_rvalid <= w_l_gnt & ~i_l_we;
      if (r_c_rvalid) begin
        r_c_rdata <= i_dm_rdata;
      end
      if (r_l_rvalid) begin
        r_l_rdata <= i_dm_rdata;
      end
    end
  end

  // Read data is presented straight from the SPRAM on the rvalid cycle, then held.
  assign o_c_rvalid = r_c_rvalid;
  assign o_l_rvalid = r_l_rvalid;
  assign o_c_rdata  = r_c_rvalid ? i_dm_rdata : r_c_rdata;
  assign o_l_rdata  = r_l_rvalid ? i_dm_rdata : r_l_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a FAIR=1 instance drives a 1-cycle ROM model,
// a FAIR=0 instance shares the inputs for the fixed-priority contention check.
module tb_dmem_arbiter;
  localparam int unsigned AW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          c_req = 0, c_we = 0, l_req = 0, l_we = 0, c_fence = 0, ready = 1;
  logic [3:0]    c_ben = 0, l_ben = 0;
  logic [AW-1:0] c_addr = 0, l_addr = 0;
  logic [31:0]   c_wdata = 0, l_wdata = 0;
  logic [31:0]   dm_rdata = 0;

  logic          c_gnt, c_rvalid, l_gnt, l_rvalid, done, dm_ren, dm_wen, fence_o;
  logic [31:0]   c_rdata, l_rdata, dm_wdata;
  logic [3:0]    dm_ben;
  logic [AW-1:0] dm_addr;

  logic          fx_c_gnt, fx_c_rvalid, fx_l_gnt, fx_l_rvalid, fx_done, fx_ren, fx_wen, fx_fence;
  logic [31:0]   fx_c_rdata, fx_l_rdata, fx_wdata;
  logic [3:0]    fx_ben;
  logic [AW-1:0] fx_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .FAIR(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_c_req(c_req), .i_c_we(c_we), .i_c_ben(c_ben), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .o_c_gnt(c_gnt), .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata),
    .i_l_req(l_req), .i_l_we(l_we), .i_l_ben(l_ben), .i_l_addr(l_addr), .i_l_wdata(l_wdata),
    .o_l_gnt(l_gnt), .o_l_rvalid(l_rvalid), .o_l_rdata(l_rdata),
    .i_c_fence_i(c_fence), .o_c_fence_done(done),
    .o_dm_ren(dm_ren), .o_dm_wen(dm_wen), .o_dm_ben(dm_ben), .o_dm_addr(dm_addr),
    .o_dm_wdata(dm_wdata), .i_dm_rdata(dm_rdata), .o_fence_i(fence_o), .i_mem_ready(ready)
  );

  dmem_arbiter #(.ADDR_W(AW), .FAIR(1'b0)) dut_fixed (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_c_req(c_req), .i_c_we(c_we), .i_c_ben(c_ben), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .o_c_gnt(fx_c_gnt), .o_c_rvalid(fx_c_rvalid), .o_c_rdata(fx_c_rdata),
    .i_l_req(l_req), .i_l_we(l_we), .i_l_ben(l_ben), .i_l_addr(l_addr), .i_l_wdata(l_wdata),
    .o_l_gnt(fx_l_gnt), .o_l_rvalid(fx_l_rvalid), .o_l_rdata(fx_l_rdata),
    .i_c_fence_i(c_fence), .o_c_fence_done(fx_done),
    .o_dm_ren(fx_ren), .o_dm_wen(fx_wen), .o_dm_ben(fx_ben), .o_dm_addr(fx_addr),
    .o_dm_wdata(fx_wdata), .i_dm_rdata(dm_rdata), .o_fence_i(fx_fence), .i_mem_ready(ready)
  );

  // 1-cycle-latency ROM: 0x10 holds 0xDEADBEEF, everything else 0xA5A5_0000 | addr.
  always @(posedge clk) begin
    if (dm_ren) dm_rdata <= (dm_addr == 14'h10) ? 32'hDEADBEEF : (32'hA5A50000 | {18'd0, dm_addr});
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (c_gnt !== 1'b0 || l_gnt !== 1'b0) begin failures++;
      $display("FAIL reset_gnt got c=%b l=%b want 0 0", c_gnt, l_gnt); end
    checks++; if (c_rvalid !== 1'b0 || l_rvalid !== 1'b0) begin failures++;
      $display("FAIL reset_rvalid got c=%b l=%b want 0 0", c_rvalid, l_rvalid); end
    checks++; if (c_rdata !== 32'd0 || l_rdata !== 32'd0) begin failures++;
      $display("FAIL reset_rdata got c=%h l=%h want 0 0", c_rdata, l_rdata); end
    checks++; if ({dm_ren, dm_wen, dm_ben, fence_o, done} !== 8'd0) begin failures++;
      $display("FAIL reset_mem got ren=%b wen=%b ben=%b fence=%b done=%b want all 0",
               dm_ren, dm_wen, dm_ben, fence_o, done); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk); c_req = 1; c_we = 0; c_addr = 14'h10; c_ben = 4'hF; #1;
    checks++; if (c_gnt !== 1'b1 || l_gnt !== 1'b0) begin failures++;
      $display("FAIL read_gnt got c=%b l=%b want 1 0", c_gnt, l_gnt); end
    checks++; if (dm_ren !== 1'b1 || dm_wen !== 1'b0 || dm_addr !== 14'h10 || dm_ben !== 4'd0)
      begin failures++; $display("FAIL read_drive got ren=%b wen=%b addr=%h ben=%b want 1 0 0010 0000",
               dm_ren, dm_wen, dm_addr, dm_ben); end
    @(negedge clk); c_req = 0; #1;
    checks++; if (c_rvalid !== 1'b1 || c_rdata !== 32'hDEADBEEF) begin failures++;
      $display("FAIL read_rvalid got v=%b d=%h want 1 deadbeef", c_rvalid, c_rdata); end
    checks++; if (l_rvalid !== 1'b0) begin failures++;
      $display("FAIL read_l_rvalid got %b want 0", l_rvalid); end
    @(negedge clk); #1;
    checks++; if (c_rvalid !== 1'b0 || c_rdata !== 32'hDEADBEEF) begin failures++;
      $display("FAIL read_hold got v=%b d=%h want 0 deadbeef", c_rvalid, c_rdata); end
  endtask

  task automatic test_contention();
    // Fresh reset so the round-robin pointer starts C-preferred.
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); c_req = 1; c_we = 0; c_addr = 14'h40; l_req = 1; l_we = 0; l_addr = 14'h50;
      #1;
      checks++; if (c_gnt !== ((i % 2) == 0) || l_gnt !== ((i % 2) == 1)) begin failures++;
        $display("FAIL fair_cycle%0d got c=%b l=%b want %b %b", i, c_gnt, l_gnt,
                 (i % 2) == 0, (i % 2) == 1); end
      checks++; if (fx_c_gnt !== 1'b1 || fx_l_gnt !== 1'b0) begin failures++;
        $display("FAIL fixed_cycle%0d got c=%b l=%b want 1 0", i, fx_c_gnt, fx_l_gnt); end
    end
    @(negedge clk); c_req = 0; l_req = 0; #1;
    checks++; if (l_rvalid !== 1'b1 || l_rdata !== 32'hA5A50050 || c_rdata !== 32'hA5A50040)
      begin failures++; $display("FAIL fair_rdata got lv=%b l=%h c=%h want 1 a5a50050 a5a50040",
               l_rvalid, l_rdata, c_rdata); end
  endtask

  task automatic test_ready_stall();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); ready = 0; c_req = 1; c_we = 1; c_addr = 14'h20;
      c_wdata = 32'h12345678; c_ben = 4'b0011; #1;
      checks++; if (c_gnt !== 1'b0 || dm_wen !== 1'b0) begin failures++;
        $display("FAIL stall_cycle%0d got gnt=%b wen=%b want 0 0", i, c_gnt, dm_wen); end
    end
    @(negedge clk); ready = 1; #1;
    checks++; if (c_gnt !== 1'b1 || dm_wen !== 1'b1 || dm_ren !== 1'b0) begin failures++;
      $display("FAIL stall_release got gnt=%b wen=%b ren=%b want 1 1 0", c_gnt, dm_wen, dm_ren); end
    checks++; if (dm_addr !== 14'h20 || dm_wdata !== 32'h12345678 || dm_ben !== 4'b0011) begin
      failures++; $display("FAIL stall_write got addr=%h data=%h ben=%b want 0020 12345678 0011",
               dm_addr, dm_wdata, dm_ben); end
    @(negedge clk); c_req = 0; #1;
    checks++; if (dm_wen !== 1'b0 || c_rvalid !== 1'b0) begin failures++;
      $display("FAIL stall_single got wen=%b rvalid=%b want 0 0", dm_wen, c_rvalid); end
  endtask

  task automatic test_fence();
    @(negedge clk); c_fence = 1; c_req = 1; c_we = 1; c_addr = 14'h24;
    c_wdata = 32'hCAFEF00D; c_ben = 4'hF; #1;
    checks++; if (fence_o !== 1'b1 || dm_wen !== 1'b0 || c_gnt !== 1'b0) begin failures++;
      $display("FAIL fence_issue got fence=%b wen=%b gnt=%b want 1 0 0", fence_o, dm_wen, c_gnt); end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk); ready = 0; #1;
      checks++; if (c_gnt !== 1'b0 || fence_o !== 1'b0 || done !== 1'b0) begin failures++;
        $display("FAIL fence_sync%0d got gnt=%b fence=%b done=%b want 0 0 0", k, c_gnt, fence_o,
                 done); end
    end
    @(negedge clk); ready = 1; #1;
    checks++; if (done !== 1'b1 || c_gnt !== 1'b0) begin failures++;
      $display("FAIL fence_done got done=%b gnt=%b want 1 0", done, c_gnt); end
    @(negedge clk); c_fence = 0; #1;
    checks++; if (done !== 1'b0 || c_gnt !== 1'b0 || fence_o !== 1'b0) begin failures++;
      $display("FAIL fence_drain got done=%b gnt=%b fence=%b want 0 0 0", done, c_gnt, fence_o); end
    @(negedge clk); #1;
    checks++; if (c_gnt !== 1'b1 || dm_wen !== 1'b1 || dm_wdata !== 32'hCAFEF00D) begin failures++;
      $display("FAIL fence_pending_write got gnt=%b wen=%b data=%h want 1 1 cafef00d",
               c_gnt, dm_wen, dm_wdata); end
    @(negedge clk); c_req = 0;
    // Ready stays high: done must still wait for the two-cycle minimum.
    @(negedge clk); c_fence = 1; #1;
    checks++; if (fence_o !== 1'b1) begin failures++;
      $display("FAIL fence2_issue got %b want 1", fence_o); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      checks++; if (done !== (k == 3)) begin failures++;
        $display("FAIL fence2_wait%0d got done=%b want %b", k, done, k == 3); end
    end
    @(negedge clk); c_fence = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk); c_req = 1; c_we = 0; c_addr = 14'h30; #1;
    checks++; if (c_gnt !== 1'b1) begin failures++;
      $display("FAIL rmid_gnt got %b want 1", c_gnt); end
    #2 rst_n = 0;
    @(negedge clk); c_req = 0; #1;
    checks++; if (c_rvalid !== 1'b0 || c_rdata !== 32'd0) begin failures++;
      $display("FAIL rmid_rvalid got v=%b d=%h want 0 0", c_rvalid, c_rdata); end
    checks++; if ({c_gnt, l_gnt, l_rvalid, dm_ren, dm_wen, dm_ben, fence_o, done} !== 11'd0 ||
                  l_rdata !== 32'd0) begin failures++;
      $display("FAIL rmid_outputs got gnt=%b%b lv=%b ren=%b wen=%b ben=%b fence=%b done=%b ld=%h want 0",
               c_gnt, l_gnt, l_rvalid, dm_ren, dm_wen, dm_ben, fence_o, done, l_rdata); end
    @(negedge clk) rst_n = 1;
    @(negedge clk); c_fence = 1; #1;
    checks++; if (fence_o !== 1'b1) begin failures++;
      $display("FAIL rsync_issue got %b want 1", fence_o); end
    @(negedge clk); #3 rst_n = 0; c_fence = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); if (k == 2) rst_n = 1; #1;
      checks++; if (done !== 1'b0 || fence_o !== 1'b0) begin failures++;
        $display("FAIL rsync_cycle%0d got done=%b fence=%b want 0 0", k, done, fence_o); end
    end
    @(negedge clk); c_req = 1; c_we = 0; c_addr = 14'h10; #1;
    checks++; if (c_gnt !== 1'b1) begin failures++;
      $display("FAIL rsync_idle_gnt got %b want 1", c_gnt); end
    @(negedge clk); c_req = 0; #1;
    checks++; if (c_rvalid !== 1'b1 || c_rdata !== 32'hDEADBEEF) begin failures++;
      $display("FAIL rsync_read got v=%b d=%h want 1 deadbeef", c_rvalid, c_rdata); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_ready_stall();
    test_fence();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port of main_mem between two requesters: the core load/store unit (C) and the program loader/debug port (L).
- Sequences the fence_i instruction-memory sync.
- Gates every access on main_mem readiness so that no write is dropped while the dirty tracker is full or syncing.
- Sits between the pipeline/loader and main_mem's i_dm_*/o_dm_rdata/i_fence_i/o_ready pins.

Parameters:
- ADDR_W, 14, word-address width (matches SPRAM depth).
- FAIR, 1, 1 = round-robin between C and L; 0 = fixed priority, C always wins.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_c_req / i_l_req  in  1  access request (C / L)
- i_c_we / i_l_we  in  1  1 = write, 0 = read
- i_c_ben / i_l_ben  in  4  byte enables (writes only)
- i_c_addr / i_l_addr  in  ADDR_W  word address
- i_c_wdata / i_l_wdata  in  32  write data
- o_c_gnt / o_l_gnt  out  1  request accepted this cycle (combinational)
- o_c_rvalid / o_l_rvalid  out  1  read data valid
- o_c_rdata / o_l_rdata  out  32  read data
- i_c_fence_i  in  1  core requests IM sync; held until o_c_fence_done
- o_c_fence_done  out  1  one-cycle pulse when the sync is complete
- o_dm_ren, o_dm_wen  out  1  to main_mem
- o_dm_ben  out  4  to main_mem
- o_dm_addr  out  ADDR_W  to main_mem
- o_dm_wdata  out  32  to main_mem
- i_dm_rdata  in  32  from main_mem
- o_fence_i  out  1  to main_mem
- i_mem_ready  in  1  main_mem o_ready

Behaviour:
- Clocking and reset: one clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values:
  - FSM = IDLE; round-robin pointer = C-preferred; rvalid pipes cleared.
  - All o_* registered outputs = 0; o_*_rdata = 0.
  - Reset mid-read suppresses that read's rvalid. Reset mid-SYNC drops the fence with no done pulse.
- FSM states:
  - IDLE: normal arbitration.
    - i_c_fence_i=1 and i_mem_ready=1 -> assert o_fence_i for exactly one cycle, grant nothing that cycle, go to SYNC.
    - i_c_fence_i=1 and i_mem_ready=0 -> no grants; stay in IDLE.
  - SYNC: no grants, o_fence_i=0, 2-bit minimum-wait counter loaded with 2.
    - Leave SYNC when counter==0 and i_mem_ready=1 -> pulse o_c_fence_done for one cycle, go to DRAIN.
    - Rationale: main_mem drops ready one cycle after the fence, so ready must not be sampled in the first 2 cycles.
  - DRAIN: one cycle, no grants, then IDLE. The core deasserts i_c_fence_i on the done pulse; DRAIN guarantees the fence is not re-detected.
- Grants:
  - A grant is possible only when state==IDLE, i_mem_ready=1 and i_c_fence_i=0.
  - With one requester, that requester wins.
  - With both requesters:
    - FAIR=0 -> C wins.
    - FAIR=1 -> the requester not granted most recently wins. The pointer updates only on a grant.
  - At most one grant per cycle.
  - Fence has priority over a simultaneous i_c_req: the request is not granted and must be held.
- Memory drive:
  - o_dm_* mux the granted requester's fields combinationally.
  - o_dm_wen = gnt & we; o_dm_ren = gnt & !we; o_dm_ben forced to 0 on reads and when idle.
  - o_dm_wen is never asserted in the same cycle as o_fence_i.
- Reads:
  - SPRAM latency is 1. Granted read at cycle N -> o_x_rvalid=1 at N+1 with o_x_rdata = i_dm_rdata, captured into a holding register.
  - o_x_rdata holds that value until the next rvalid for the same requester.
  - Back-to-back reads give rvalid every cycle.
- Writes: complete on grant; no response.
- Requester protocol: req and its fields stay stable until gnt. Dropping req before gnt is permitted (the request is abandoned) and must not corrupt state.
- i_mem_ready low while in IDLE: no grants, requests wait, no timeout.

Test Plan:
1. Reset then single read: C reads addr 0x0010 (memory holds 0xDEADBEEF) -> o_c_gnt same cycle, o_c_rvalid next cycle with o_c_rdata=0xDEADBEEF, o_l_rvalid stays 0.
2. Contention, FAIR=1: C and L both request continuously for 6 cycles -> grants alternate C,L,C,L,C,L. With FAIR=0 -> C granted all 6 cycles.
3. Ready stall: i_mem_ready=0 for 5 cycles while C writes 0x12345678, ben=4'b0011, to 0x0020 -> no gnt and o_dm_wen=0 during the stall; single write on the cycle ready returns.
4. Fence: C asserts fence with C write also pending; i_mem_ready drops 1 cycle after o_fence_i for 7 cycles -> o_fence_i one cycle with o_dm_wen=0, no grants during SYNC/DRAIN, o_c_fence_done pulses once after ready returns, pending write granted after DRAIN.
5. Reset mid-operation: assert i_rst_n=0 the cycle after a granted read and during SYNC -> rvalid never asserts, FSM returns to IDLE, no done pulse, all outputs 0.
